// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and constants for the core memory-port
//                arbitration logic: arbiter state, transaction owner and
//                the fixed byte-enable pattern used for instruction fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Arbiter state: idle, or one transaction outstanding for a given owner.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } state_t;

    // Which requester wins the memory port this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    // Instruction fetches always read a full word.
    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage : core_pkg
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_port_arbiter
//  Description : Shares the single memory port between instruction fetch and
//                the load/store unit. LS normally wins; a starvation counter
//                hands fetch priority after STARVE_MAX denied cycles. One
//                transaction is tracked and its response routed to the owner.
//                Fetch responses made stale by a redirect are dropped.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rstn                     clock, synchronous active-low reset
//    if_req/if_addr/if_flush       fetch request, address, redirect
//    if_gnt/if_rvalid/if_rdata     fetch accept, response valid, data
//    ls_req/we/be/addr/wdata       load/store request
//    ls_gnt/ls_rvalid/ls_rdata     load/store accept, response valid, data
//    mem_req/we/be/addr/wdata      request to memory (muxed from winner)
//    mem_gnt/mem_rvalid/mem_rdata  memory accept, response valid, data
// ============================================================================
module imem_port_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int                 c_cnt_w      = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_drop;
    logic               w_drop_nxt;
    logic [c_cnt_w-1:0] r_starve_cnt;
    logic [c_cnt_w-1:0] w_starve_nxt;
    owner_t             w_winner;
    logic               w_free;
    logic               w_if_elig;

    // The port can take a new request when idle, or in the same cycle the
    // outstanding response returns (back-to-back issue).
    assign w_free    = (r_state == IDLE) || mem_rvalid;
    assign w_if_elig = if_req && !if_flush;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_drop       <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_drop       <= w_drop_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_winner     = OWN_NONE;
        w_state_nxt  = r_state;
        w_drop_nxt   = r_drop;
        w_starve_nxt = r_starve_cnt;
        if_gnt       = 1'b0;
        ls_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        ls_rvalid    = 1'b0;
        if_rdata     = mem_rdata;
        ls_rdata     = mem_rdata;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'h0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;

        // Arbitration: LS first until fetch has been starved long enough.
        if (w_free) begin
            if (ls_req && (r_starve_cnt < c_starve_max)) begin
                w_winner = OWN_LS;
            end else if (w_if_elig) begin
                w_winner = OWN_IF;
            end else if (ls_req) begin
                w_winner = OWN_LS;
            end
        end

        case (w_winner)
            OWN_IF: begin
                mem_req  = 1'b1;
                mem_be   = FETCH_BE;
                mem_addr = if_addr;
                if_gnt   = mem_gnt;
            end
            OWN_LS: begin
                mem_req   = 1'b1;
                mem_we    = ls_we;
                mem_be    = ls_be;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
                ls_gnt    = mem_gnt;
            end
            default: ;
        endcase

        // Response routing; a response seen in IDLE belongs to nobody.
        case (r_state)
            WAIT_IF: begin
                if_rvalid = mem_rvalid && !r_drop && !if_flush;
                if (mem_rvalid) begin
                    w_drop_nxt = 1'b0;
                end else if (if_flush) begin
                    w_drop_nxt = 1'b1;
                end
            end
            WAIT_LS: ls_rvalid = mem_rvalid;
            default: ;
        endcase

        if (if_gnt) begin
            w_state_nxt = WAIT_IF;
        end else if (ls_gnt) begin
            w_state_nxt = WAIT_LS;
        end else if ((r_state != IDLE) && mem_rvalid) begin
            w_state_nxt = IDLE;
        end

        // Count cycles fetch is ready but held off; saturate at the limit.
        if (if_gnt || !w_if_elig) begin
            w_starve_nxt = '0;
        end else if (r_starve_cnt < c_starve_max) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

endmodule : imem_port_arbiter
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_port_arbiter
//  Description : Self-checking bench for imem_port_arbiter. A table of
//                per-cycle input/expected-output rows walks through fetch
//                streaming, store priority, redirect drop, no-grant hold and
//                response routing; hand sequences cover starvation and
//                reset during an outstanding load/store.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, if_flush, ls_req, ls_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_be;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        fl;
        logic        lr;
        logic        lw;
        logic [3:0]  lb;
        logic [31:0] la;
        logic [31:0] ld;
        logic        mg;
        logic        mv;
        logic [31:0] md;
        logic [3:0]  ectl;   // {if_gnt, if_rvalid, ls_gnt, ls_rvalid}
        logic        ereq;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] ea;
        logic [31:0] ed;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ir, input logic [31:0] ia, input logic fl,
                       input logic lr, input logic lw, input logic [3:0] lb,
                       input logic [31:0] la, input logic [31:0] ld,
                       input logic mg, input logic mv, input logic [31:0] md,
                       input logic [3:0] ectl, input logic ereq, input logic ewe,
                       input logic [3:0] ebe, input logic [31:0] ea,
                       input logic [31:0] ed);
        vec_t v;
        v.ir = ir; v.ia = ia; v.fl = fl;
        v.lr = lr; v.lw = lw; v.lb = lb; v.la = la; v.ld = ld;
        v.mg = mg; v.mv = mv; v.md = md;
        v.ectl = ectl; v.ereq = ereq; v.ewe = ewe; v.ebe = ebe; v.ea = ea; v.ed = ed;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    // Both requesters asserting every cycle against a 1-cycle memory; pat
    // gives the expected winner per cycle ("L" or "I").
    task automatic run_pattern(input string tag, input string pat, input bit drain);
        logic        exp_ls;
        logic [33:0] act, exp;
        for (int i = 0; i < pat.len(); i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h400; if_flush = 1'b0;
            ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h800; ls_wdata = 32'h0;
            mem_gnt = 1'b1; mem_rvalid = (i != 0); mem_rdata = 32'h0;
            #2;
            exp_ls = (pat[i] == "L");
            act = {if_gnt, ls_gnt, mem_addr};
            exp = {!exp_ls, exp_ls, (exp_ls ? 32'h800 : 32'h400)};
            n_vec++;
            if (act !== exp) begin
                n_miss++;
                $display("FAIL %s[%0d]: {if_gnt,ls_gnt,mem_addr} got %h want %h", tag, i, act, exp);
            end
        end
        if (drain) begin
            @(negedge clk);
            idle_inputs();
            mem_rvalid = 1'b1;
        end
    endtask

    logic [137:0] act_b, exp_b;

    initial begin
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        //   ir ia        fl lr lw lb    la         ld            mg mv md          ectl     rq we be    ea         ed
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,   4'b0000, 0, 0, 4'h0, 32'h0,   32'h0);
        add(1, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0,   4'b1000, 1, 0, 4'hF, 32'h0,   32'h0);
        add(1, 32'h4,  0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 1, 32'hA0,  4'b1100, 1, 0, 4'hF, 32'h4,   32'h0);
        add(1, 32'h8,  0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 1, 32'hA4,  4'b1100, 1, 0, 4'hF, 32'h8,   32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'hA8,  4'b0100, 0, 0, 4'h0, 32'h0,   32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h55,  4'b0000, 0, 0, 4'h0, 32'h0,   32'h0);
        // store beats concurrent fetch, fetch follows on the response cycle
        add(1, 32'h40, 0, 1, 1, 4'h3, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0,   4'b0010, 1, 1, 4'h3, 32'h100, 32'hDEADBEEF);
        add(1, 32'h40, 0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 1, 32'h0,   4'b1001, 1, 0, 4'hF, 32'h40,  32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h11,  4'b0100, 0, 0, 4'h0, 32'h0,   32'h0);
        // flush after grant, late response dropped
        add(1, 32'h80, 0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0,   4'b1000, 1, 0, 4'hF, 32'h80,  32'h0);
        add(0, 32'h0,  1, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,   4'b0000, 0, 0, 4'h0, 32'h0,   32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,   4'b0000, 0, 0, 4'h0, 32'h0,   32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,   4'b0000, 0, 0, 4'h0, 32'h0,   32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h13,  4'b0000, 0, 0, 4'h0, 32'h0,   32'h0);
        add(1, 32'h84, 0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0,   4'b1000, 1, 0, 4'hF, 32'h84,  32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h22,  4'b0100, 0, 0, 4'h0, 32'h0,   32'h0);
        // flush coinciding with the response
        add(1, 32'h90, 0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0,   4'b1000, 1, 0, 4'hF, 32'h90,  32'h0);
        add(1, 32'h94, 1, 0, 0, 4'h0, 32'h0,   32'h0,        1, 1, 32'h33,  4'b0000, 0, 0, 4'h0, 32'h0,   32'h0);
        add(1, 32'h94, 0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0,   4'b1000, 1, 0, 4'hF, 32'h94,  32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h44,  4'b0100, 0, 0, 4'h0, 32'h0,   32'h0);
        // flushed fetch in a free cycle, LS still wins
        add(1, 32'hA0, 1, 1, 0, 4'hF, 32'h200, 32'h0,        1, 0, 32'h0,   4'b0010, 1, 0, 4'hF, 32'h200, 32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h66,  4'b0001, 0, 0, 4'h0, 32'h0,   32'h0);
        // memory withholds grant, request stays up
        add(1, 32'hB0, 0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,   4'b0000, 1, 0, 4'hF, 32'hB0,  32'h0);
        add(1, 32'hB0, 0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0,   4'b1000, 1, 0, 4'hF, 32'hB0,  32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h77,  4'b0100, 0, 0, 4'h0, 32'h0,   32'h0);
        // no new request while a load is outstanding
        add(0, 32'h0,  0, 1, 0, 4'hF, 32'h300, 32'h0,        1, 0, 32'h0,   4'b0010, 1, 0, 4'hF, 32'h300, 32'h0);
        add(1, 32'hC0, 0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,   4'b0000, 0, 0, 4'h0, 32'h0,   32'h0);
        add(1, 32'hC0, 0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 1, 32'h88,  4'b1001, 1, 0, 4'hF, 32'hC0,  32'h0);
        add(0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h99,  4'b0100, 0, 0, 4'h0, 32'h0,   32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if_req = vq[i].ir; if_addr = vq[i].ia; if_flush = vq[i].fl;
            ls_req = vq[i].lr; ls_we = vq[i].lw; ls_be = vq[i].lb;
            ls_addr = vq[i].la; ls_wdata = vq[i].ld;
            mem_gnt = vq[i].mg; mem_rvalid = vq[i].mv; mem_rdata = vq[i].md;
            #2;
            act_b = {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, mem_be,
                     mem_addr, mem_wdata, if_rdata, ls_rdata};
            exp_b = {vq[i].ectl, vq[i].ereq, vq[i].ewe, vq[i].ebe,
                     vq[i].ea, vq[i].ed, vq[i].md, vq[i].md};
            n_vec++;
            if (act_b !== exp_b) begin
                n_miss++;
                $display("FAIL vec%0d: outputs got %h want %h", i, act_b, exp_b);
            end
        end

        // Starvation guard: LS x4 then one fetch, repeating.
        run_pattern("starve", "LLLLILLLLI", 1'b1);

        // Reset while a load/store is outstanding with fetch partly starved.
        run_pattern("pre_rst", "LLL", 1'b0);
        @(negedge clk);
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5A;
        #2;
        n_vec++;
        if ({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 74'h0) begin
            n_miss++;
            $display("FAIL post_rst: ctl got %b%b%b%b req %b we %b be %h addr %h wdata %h want all 0",
                     if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        run_pattern("rst_restart", "LLLLI", 1'b1);

        @(negedge clk);
        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_imem_port_arbiter
`default_nettype wire
